// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and load/store; data wins over fetch.
// Latency: 2 cycles minimum from a request being sampled in IDLE to its one-cycle valid pulse, plus one per wait cycle.
// Backpressure: requesters hold their level requests until their valid pulse; stall holds the PC meanwhile. MEM_TIMEOUT_EN bounds wait states and raises a sticky err.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch requester
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    // load/store requester
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    // pipeline hold
    output logic                stall,
    // shared memory bus
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                err
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_valid_q, d_valid_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                err_q, err_d;
    logic                tmo_hit;

    // Limit reached on the TIMEOUT-th wait cycle that passes without an ack.
    assign tmo_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

    // The bus is requested exactly while a wait state is occupied, so reset drops it at once.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;

    // A request whose valid is pulsing this cycle is already served, so it does not hold the PC.
    assign stall = (d_req & ~d_valid_q) | (if_req & ~if_valid_q);

    // Next-state and datapath decisions: arbitration in IDLE, completion in the wait states.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_valid_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_TIMEOUT_EN
                // Every wait state is entered from IDLE, so clearing here clears on entry.
                wait_cnt_d = '0;
`endif
                // A requester whose valid is high right now was just served; skipping it
                // prevents a level-held request from being issued twice.
                if (d_req && !d_valid_q) begin
                    state_d     = D_WAIT;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wmask_d = d_wmask;
                end else if (if_req && !if_valid_q) begin
                    state_d     = I_WAIT;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wmask_d = '0;
                end
            end

            D_WAIT: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    d_valid_d = 1'b1;
                    // Stores leave the last load result in place.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    d_valid_d = 1'b1;
                    d_rdata_d = '0;
                    err_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end

            I_WAIT: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
`ifdef MEM_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d    = IDLE;
                    if_valid_d = 1'b1;
                    if_rdata_d = '0;
                    err_d      = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait-state counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and stall sequencer between the instruction-fetch path (driven by the program counter) and the load/store data path. Both requesters share one external memory bus. The block serialises their accesses through a small FSM and returns read data with one-cycle valid pulses. It also drives the `stall` signal that holds the PC while any access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (`DATA_W/8` byte lanes)
- `TIMEOUT`, 16, wait-state limit in cycles (used only with `MEM_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, level, held until `if_valid`
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_rdata`  out  DATA_W  fetched instruction, registered
- `if_valid`  out  1  one-cycle pulse, `if_rdata` valid
- `d_req`  in  1  data request, level, held until `d_valid`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wmask`  in  DATA_W/8  store byte enables
- `d_rdata`  out  DATA_W  load data, registered
- `d_valid`  out  1  one-cycle pulse, data access complete
- `stall`  out  1  combinational; 1 = hold PC
- `mem_req`, `mem_we`  out  1  bus request / write strobe
- `mem_addr`  out  ADDR_W  bus address
- `mem_wdata`  out  DATA_W  bus write data
- `mem_wmask`  out  DATA_W/8  bus byte enables
- `mem_rdata`  in  DATA_W  bus read data
- `mem_ack`  in  1  bus completion, single cycle
- `err`  out  1  sticky timeout flag

## Operation
FSM states and transitions:
- **IDLE**
  - If `d_req` is high and `d_valid` is low: latch `d_*` onto `mem_*` and go to **D_WAIT**.
  - Else if `if_req` is high and `if_valid` is low: latch `if_addr`, set `mem_we=0`, `mem_wmask=0`, and go to **I_WAIT**.
  - Data has strict priority over fetch. There is no starvation, because a data request only exists after its instruction has been fetched.
- **D_WAIT**
  - `mem_req=1`.
  - On `mem_ack`: drop `mem_req`, pulse `d_valid`, and go to **IDLE**.
  - For a load, `d_rdata <= mem_rdata`. For a store, `d_rdata` holds its previous value.
- **I_WAIT**
  - `mem_req=1`.
  - On `mem_ack`: `if_rdata <= mem_rdata`, pulse `if_valid`, and go to **IDLE**.

Rules:
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wmask` are registered and stable for the whole time `mem_req` is high.
- A request is not accepted in the cycle its own valid pulse is high, so a level-held request is never serviced twice.
- `stall = (d_req & ~d_valid) | (if_req & ~if_valid)`.
- If a requester drops its request mid-transaction, the bus access still completes and the valid pulse is still issued.
- `mem_ack` seen while in **IDLE** is ignored.

Reset (`rst` low, asynchronous):
- State returns to **IDLE**.
- All outputs go to 0: `mem_*`, `if_rdata`, `d_rdata`, both valids and `err`.
- `stall` follows its inputs combinationally.
- Reset during a wait state abandons the access: `mem_req` drops immediately and no valid pulse is issued.

## Timing
- Request sampled high in IDLE at edge N → `mem_req` high after edge N.
- Earliest `mem_ack` is in the cycle after edge N → valid pulse after edge N+1.
- Minimum access latency is 2 cycles. The next request is accepted at the earliest at the edge after the valid pulse.
- A back-to-back fetch with zero-wait memory therefore issues one access every 3 cycles.
- If `d_req` and `if_req` rise in the same cycle, data is serviced first. The fetch starts in the cycle after `d_valid`.
- Reset has priority over a simultaneous `mem_ack`.

## Configuration
- `MEM_TIMEOUT_EN` defined: a wait-state counter runs in **D_WAIT** and **I_WAIT**.
  - The counter clears on state entry.
  - If it reaches `TIMEOUT` without `mem_ack`: drop `mem_req`, pulse the corresponding valid with rdata = 0, set `err` (sticky until reset), and go to **IDLE**.
  - An ack arriving in the same cycle as the limit wins: it completes normally and does not set `err`.
- `MEM_TIMEOUT_EN` undefined: no counter is instantiated, wait states last indefinitely, and `err` is tied to 0.

## Test plan
- **Reset:** `rst` low mid-D_WAIT → `mem_req`=0 immediately, no `d_valid`, all outputs 0; fetch at `if_addr`=0 proceeds after release.
- **Fetch, zero-wait:** `if_req`=1, `if_addr`=0x10, `mem_ack` in the first wait cycle with `mem_rdata`=0x00500093 → `if_valid` pulse 2 cycles after the request, `if_rdata`=0x00500093, `stall` high until the pulse cycle.
- **Collision:** `d_req` (load, 0x200) and `if_req` (0x14) rise together → the data access appears on the bus first, `d_valid` fires, then `mem_addr`=0x14 one cycle later.
- **Store with 3 wait states:** `d_we`=1, `d_wdata`=0xDEADBEEF, `d_wmask`=4'b0011 → bus fields stable for 4 cycles, `d_valid` after the ack, `d_rdata` unchanged.
- **Level-held request:** `if_req` held high across `if_valid` → exactly one access per valid, no duplicate in the pulse cycle.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT`=4):** load with no `mem_ack` → `mem_req` drops after 4 wait cycles, `d_valid`=1 with `d_rdata`=0, `err` stays 1 until reset.
